seq_array_multiplier: RTL and testbench
=======================================

Name: seq_array_multiplier

Overview:
Parametrised sequential shift-add multiplier. It is the next generation after the team's combinational TT top-level arithmetic.
- Accepts two WIDTH-bit operands over a valid/ready handshake.
- Computes the 2*WIDTH-bit product in WIDTH iterations.
- Holds the result under output back-pressure.
- Sits behind the tt_um top-level, which maps ui_in/uio_in to operands and uo_out to product slices.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands a/b are valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  multiplicand; sampled on the input handshake.
- b  input  WIDTH  multiplier; sampled on the input handshake.
- out_valid  output  1  product is valid; high only in DONE.
- out_ready  input  1  consumer accepts the product.
- product  output  2*WIDTH  result register.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, accumulator=0, counter=0.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on in_valid&&in_ready. On that edge:
  - mcand<=a, mplier<=b, acc<=0, cnt<=0.
- RUN, one iteration per clock:
  - if mplier[0], acc_hi <= acc_hi + mcand, with a WIDTH+1-bit carry.
  - {carry,acc,mplier} shifts right by 1; cnt<=cnt+1.
  - When cnt==WIDTH-1, the edge performs the final iteration, loads product, and moves to DONE.
- Latency: out_valid is high exactly WIDTH edges after the accepting edge, e.g. 8 edges for WIDTH=8.
- DONE: out_valid=1; product stays stable until the output handshake.
  - DONE -> IDLE on out_valid&&out_ready; product keeps its last value after the handshake.
- in_valid in RUN/DONE is ignored (in_ready=0); operands are not captured and no queue exists.
- in_valid and out_ready may be high in the same cycle in DONE. The result is consumed; the new operand is accepted only on a later cycle in IDLE, so there is no pass-through.
- Arithmetic: unsigned. The product is exact and never overflows 2*WIDTH bits.
  - Max case: (2^WIDTH-1)^2 fits in 2*WIDTH bits.
- Zero operands still take the full WIDTH cycles (fixed latency).
- rst asserted mid-RUN or in DONE aborts immediately to the reset values; the partial result is discarded.

Optional Feature:
- Macro: MUL_SIGNED_EN.
- Defined:
  - Adds input port is_signed (1 bit), sampled on the input handshake.
  - When is_signed=1, a and b are two's complement. At load, the magnitudes are stored and neg=a[MSB]^b[MSB] is registered.
  - On the DONE transition, product <= neg ? -acc : acc.
  - Latency is unchanged.
  - The -2^(WIDTH-1) * -2^(WIDTH-1) case yields +2^(2*WIDTH-2), which fits.
- Not defined: no is_signed port; unsigned only; no negation logic synthesised.

Decomposition:
- Package mul_pkg:
  - state enum typedef (IDLE/RUN/DONE, 2 bits).
  - DEFAULT_WIDTH=8.
  - cnt_w function.
- One sub-module: mul_shift_add_step.
  - Combinational single iteration: inputs acc, mplier, mcand; outputs next acc/mplier.
  - The top module owns the FSM, counter, handshake and output register.

Test Plan:
- WIDTH=8, a=13, b=11, out_ready=1 -> product=143 (0x008F); out_valid high exactly 8 edges after accept, for 1 cycle.
- a=255, b=255 -> product=65025 (0xFE01); a=0, b=200 -> product=0, still 8-cycle latency.
- Back-pressure: out_ready=0 for 5 cycles in DONE -> product and out_valid stable, in_ready=0, new in_valid ignored. Then out_ready=1 -> IDLE next edge; a new operand pair 7*6 gives 42.
- Reset mid-RUN (after 3 iterations of 100*100) -> all outputs return to reset values immediately. A following 3*4 yields 12.
- Back-to-back: continuous in_valid with out_ready=1 over 4 random pairs -> each product matches the reference model. Throughput is one result per WIDTH+2 cycles.
- MUL_SIGNED_EN, is_signed=1: -3*5 -> 0xFFF1; -128*-128 -> 0x4000; is_signed=0 with 0xFD*5 -> 1265 (0x04F1).

Source files
------------

// File: rtl/mul_pkg.sv
// mul_pkg: shared FSM state type, default width and counter-width helper for the sequential multiplier.
package mul_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DEFAULT_WIDTH = 8;
  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction
endpackage

// File: rtl/mul_shift_add_step.sv
// mul_shift_add_step: one combinational shift-add iteration over {carry, acc, mplier}.
module mul_shift_add_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mplier,
  input  logic [WIDTH-1:0] mcand,
  output logic [WIDTH-1:0] acc_nx,
  output logic [WIDTH-1:0] mplier_nx
);
  logic [WIDTH:0] sum;
  assign sum       = {1'b0, acc} + {1'b0, mplier[0] ? mcand : '0};
  assign acc_nx    = sum[WIDTH:1];
  assign mplier_nx = {sum[0], mplier[WIDTH-1:1]};
endmodule

// File: rtl/seq_array_multiplier.sv
// seq_array_multiplier: valid/ready shift-add multiplier, WIDTH iterations per product.
// Define MUL_SIGNED_EN to add the is_signed port and two's-complement operand support.
module seq_array_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef MUL_SIGNED_EN
  input  logic               is_signed,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);
  localparam int CNT_W = cnt_w(WIDTH);
  state_t state, state_nx;
  logic [WIDTH-1:0] acc, mplier, mcand, acc_nx, mplier_nx, a_mag, b_mag;
  logic [CNT_W-1:0] cnt;
  logic [2*WIDTH-1:0] full, result;
  logic accept, last;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  assign accept    = in_valid && in_ready;
  assign last      = state == RUN && cnt == CNT_W'(WIDTH - 1);
  assign full      = {acc_nx, mplier_nx};
`ifdef MUL_SIGNED_EN
  // Iterate on magnitudes; the sign is reapplied once when the product is loaded.
  logic neg;
  assign a_mag  = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag  = (is_signed && b[WIDTH-1]) ? -b : b;
  assign result = neg ? -full : full;
  always_ff @(posedge clk or posedge rst)
    if (rst) neg <= 1'b0;
    else if (accept) neg <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
`else
  assign a_mag  = a;
  assign b_mag  = b;
  assign result = full;
`endif
  mul_shift_add_step #(.WIDTH(WIDTH)) u_step (
    .acc(acc), .mplier(mplier), .mcand(mcand), .acc_nx(acc_nx), .mplier_nx(mplier_nx)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = accept ? RUN : IDLE;
    if (state == RUN) state_nx = last ? DONE : RUN;
    if (state == DONE) state_nx = out_ready ? IDLE : DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc     <= '0;
      mplier  <= '0;
      mcand   <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (accept) begin
      mcand  <= a_mag;
      mplier <= b_mag;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      acc    <= acc_nx;
      mplier <= mplier_nx;
      cnt    <= cnt + 1'b1;
      if (last) product <= result;
    end
endmodule

// File: tb/tb_seq_array_multiplier.sv
// tb_seq_array_multiplier: directed self-checking bench for seq_array_multiplier at WIDTH=8.
module tb_seq_array_multiplier;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1, is_signed = 0;
  logic in_ready, out_valid, busy;
  logic [7:0] a = 0, b = 0;
  logic [15:0] product;
  int total = 0, bad = 0, cyc = 0;

  seq_array_multiplier #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
`ifdef MUL_SIGNED_EN
    .is_signed(is_signed),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [7:0] x, input logic [7:0] y);
    a = x;
    b = y;
    in_valid = 1;
    tick();
    in_valid = 0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic mul(input string tag, input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp);
    int n;
    start(x, y);
    check({tag, "_busy"}, {in_ready, busy}, 2'b01);
    wait_done(n);
    check({tag, "_lat"}, n, 8);
    check({tag, "_prod"}, product, exp);
    tick();
    check({tag, "_onecyc"}, {out_valid, in_ready}, 2'b01);
  endtask

  int n;
  int acc_cyc, prev_cyc;
  logic [7:0] pa[4] = '{8'h5A, 8'd200, 8'd1, 8'd128};
  logic [7:0] pb[4] = '{8'hC3, 8'd3, 8'd255, 8'd2};
  logic [15:0] pe[4] = '{16'h448E, 16'd600, 16'd255, 16'd256};

  initial begin
    #1;
    check("rst_vals", {in_ready, out_valid, busy, product}, {3'b100, 16'h0});
    tick();
    rst = 0;
    mul("m13x11", 8'd13, 8'd11, 16'h008F);
    mul("m255sq", 8'd255, 8'd255, 16'hFE01);
    mul("m0x200", 8'd0, 8'd200, 16'h0000);
    out_ready = 0;
    start(8'd10, 8'd20);
    wait_done(n);
    check("bp_lat", n, 8);
    a = 9;
    b = 9;
    in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold", {out_valid, in_ready, busy, product}, {3'b101, 16'd200});
    end
    in_valid = 0;
    out_ready = 1;
    tick();
    check("bp_release", {out_valid, in_ready, busy, product}, {3'b010, 16'd200});
    mul("m7x6", 8'd7, 8'd6, 16'd42);
    start(8'd100, 8'd100);
    repeat (3) tick();
    rst = 1;
    #1;
    check("rst_mid", {in_ready, out_valid, busy, product}, {3'b100, 16'h0});
    tick();
    rst = 0;
    mul("m3x4", 8'd3, 8'd4, 16'd12);
    in_valid = 1;
    prev_cyc = -1;
    for (int i = 0; i < 4; i++) begin
      a = pa[i];
      b = pb[i];
      n = 0;
      while (!in_ready && n < 40) begin
        tick();
        n++;
      end
      tick();
      acc_cyc = cyc;
      if (prev_cyc >= 0) check("b2b_tput", acc_cyc - prev_cyc, 10);
      prev_cyc = acc_cyc;
      wait_done(n);
      check("b2b_prod", product, pe[i]);
      tick();
    end
    in_valid = 0;
    tick();
`ifdef MUL_SIGNED_EN
    is_signed = 1;
    mul("s_m3x5", 8'hFD, 8'd5, 16'hFFF1);
    mul("s_m128sq", 8'h80, 8'h80, 16'h4000);
    is_signed = 0;
    mul("u_fdx5", 8'hFD, 8'd5, 16'h04F1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
